// File: rtl/i2s_rx_unit.sv
// I2S receiver: recovers 24-bit stereo frames from sck/ws/sdi sampled in the
// clk domain and buffers them in a small circular FIFO with a valid/ready output.
module i2s_rx_unit #(
    parameter int FIFO_SIZE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_enable_in,
    input  logic        sck_in,
    input  logic        ws_in,
    input  logic        sdi_in,
    output logic [47:0] audio_out,
    output logic        audio_valid_out,
    input  logic        audio_ready_in,
    output logic        frame_error_out,
    output logic        overflow_out
);
    localparam int PW = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1;
    localparam int CW = $clog2(FIFO_SIZE + 1);

    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

    state_t        state;
    logic          sck_r;
    logic          ws_prev;
    logic [4:0]    bit_cnt;
    logic [23:0]   shift_reg;
    logic [23:0]   left_word;
    logic [47:0]   mem [FIFO_SIZE];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic        sck_rise;
    logic        ws_change;
    logic        len_ok;
    logic [23:0] word;
    logic        push;
    logic        pop;
    logic        full;
    logic        do_wr;

    // Handshake: a frame transfers on any clk edge where audio_valid_out and
    // audio_ready_in are both high; audio_out is held while valid waits for ready.
    assign sck_rise  = sck_in & ~sck_r;
    assign ws_change = ws_in ^ ws_prev;
    assign word      = {shift_reg[22:0], sdi_in};
    assign len_ok    = (bit_cnt == 5'd23);
    assign push      = rx_enable_in && (state == RUN) && sck_rise && ws_change && ws_prev && len_ok;
    assign pop       = audio_valid_out && audio_ready_in;
    assign full      = (count == CW'(FIFO_SIZE));
    assign do_wr     = push && (!full || pop);

    assign audio_valid_out = (count != '0);
    assign audio_out       = audio_valid_out ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            sck_r           <= 1'b0;
            ws_prev         <= 1'b0;
            bit_cnt         <= '0;
            shift_reg       <= '0;
            left_word       <= '0;
            frame_error_out <= 1'b0;
        end else begin
            frame_error_out <= 1'b0;
            sck_r           <= sck_in;
            if (sck_rise) ws_prev <= ws_in;
            if (!rx_enable_in) begin
                state     <= IDLE;
                bit_cnt   <= '0;
                shift_reg <= '0;
            end else begin
                case (state)
                    IDLE: state <= SYNC;
                    SYNC: begin
                        // Lock onto the right->left boundary so the first word is always left.
                        if (sck_rise && ws_change && ws_prev) begin
                            state   <= RUN;
                            bit_cnt <= '0;
                        end
                    end
                    RUN: begin
                        if (sck_rise) begin
                            shift_reg <= word;
                            if (ws_change) begin
                                bit_cnt <= '0;
                                if (!len_ok) begin
                                    frame_error_out <= 1'b1;
                                    state           <= SYNC;
                                end else if (!ws_prev) begin
                                    left_word <= word;
                                end
                            end else if (bit_cnt >= 5'd24) begin
                                bit_cnt         <= 5'd25;
                                frame_error_out <= 1'b1;
                                state           <= SYNC;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= {left_word, word};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_out <= 1'b0;
        end else if (!rx_enable_in) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_out <= 1'b0;
        end else begin
            overflow_out <= push && full && !pop;
            if (do_wr) wr_ptr <= (wr_ptr == PW'(FIFO_SIZE - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)   rd_ptr <= (rd_ptr == PW'(FIFO_SIZE - 1)) ? '0 : rd_ptr + 1'b1;
            case ({do_wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
